interrupt_arbiter: RTL and testbench
====================================

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter FRAME_ISR_ADDR, default 27'd16: jump target of the frame-tick service routine.
REQ-002 Parameter JUMP_ISR_ADDR, default 27'd64: jump target of the jump-key service routine.
REQ-003 Parameter AUX_ISR_ADDR, default 27'd128: jump target of the auxiliary-event service routine.
REQ-004 Parameter DEBOUNCE_CYCLES, default 16: sysclk cycles the synchronized jump_key level must stay stable before it is accepted.
REQ-005 sysclk  input  1  system clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 frame_rt_clk  input  1  divided frame-rate clock, asynchronous to sysclk.
REQ-008 jump_key  input  1  raw player button, asynchronous, active-high.
REQ-009 aux_evt  input  1  single-cycle event pulse, synchronous to sysclk.
REQ-010 irq_enable  input  1  processor interrupt enable; low blocks new presentations.
REQ-011 irq_ack  input  1  processor accepted the presented instruction.
REQ-012 irq_valid  output  1  interrupt_instruction is valid and held.
REQ-013 interrupt_instruction  output  32  injected instruction.
REQ-014 irq_src  output  2  source being presented: 0 frame, 1 jump, 2 aux, 3 none.

Function
REQ-015 frame_rt_clk and jump_key each pass through a 2-flop synchronizer.
REQ-016 A rising edge of the synchronized frame_rt_clk sets pending[0] on the 3rd sysclk edge after the raw input rises (2 synchronizer stages + 1 edge-detect stage).
REQ-017 Debounce: synchronized jump_key held unchanged for DEBOUNCE_CYCLES consecutive cycles updates the accepted level; any change restarts the counter; an accepted 0->1 transition sets pending[1].
REQ-018 aux_evt high sets pending[2] on the next edge.
REQ-019 Pending bits are sticky until their presentation is acknowledged; a repeat event while already pending merges into one request.
REQ-020 FSM states: IDLE, PRESENT, GAP.
REQ-021 IDLE: when irq_enable=1 and any pending bit is set, select the lowest index (frame > jump > aux), latch it, and enter PRESENT on the next edge.
REQ-022 PRESENT: irq_valid=1; interrupt_instruction={5'b00011, ISR address of latched source}; irq_src=latched index; outputs are held stable until irq_ack.
REQ-023 PRESENT with irq_ack=1: clear that source's pending bit and enter GAP; irq_valid drops on the following edge.
REQ-024 GAP lasts exactly one cycle with irq_valid=0, then returns to IDLE; back-to-back presentations are therefore separated by at least one idle cycle.
REQ-025 When not in PRESENT: irq_valid=0, interrupt_instruction=32'd0 (nop), irq_src=3.
REQ-026 A new event for a source arriving in the same cycle its pending bit is cleared by irq_ack leaves the bit set (set wins).
REQ-027 irq_ack outside PRESENT is ignored.
REQ-028 Dropping irq_enable during PRESENT does not withdraw the presentation.

Reset
REQ-029 reset=1 asynchronously clears synchronizers, debounce counter and accepted level (0), pending bits, FSM (IDLE), and all outputs to their REQ-025 values.
REQ-030 A presentation in progress when reset asserts is discarded and is not re-presented.

Configuration
REQ-031 Macro IRQ_DROP_COUNT_EN: when defined, add output drop_count (8 bits) counting events merged per REQ-019, saturating at 255 and cleared by reset; when undefined, drop_count does not exist and no counter logic is present.

Verification
REQ-032 Raise frame_rt_clk once, irq_enable=1 -> pending[0] set 3 cycles later; irq_valid=1 with instruction 32'h18000010 and irq_src=0; after irq_ack, irq_valid=0 and one GAP cycle follows.
REQ-033 Press jump_key for 20 cycles with DEBOUNCE_CYCLES=16 -> exactly one presentation of 32'h18000040; a 10-cycle glitch -> no presentation.
REQ-034 Frame, jump and aux all pending -> presented in order irq_src 0, 1, 2, each separated by at least one cycle with irq_valid=0.
REQ-035 irq_enable=0 with aux_evt pulsed 3 times -> no irq_valid; after irq_enable=1 -> one presentation of 32'h18000080; drop_count=2 when IRQ_DROP_COUNT_EN is defined.
REQ-036 Assert reset while irq_valid=1 -> irq_valid=0, interrupt_instruction=0, and irq_src=3 immediately; no presentation after reset deasserts.
REQ-037 aux_evt pulse in the same cycle as irq_ack for aux -> pending[2] remains set and aux is re-presented after GAP.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: prioritised interrupt injection (frame > jump > aux) with a one-cycle gap between presentations.
// Optional IRQ_DROP_COUNT_EN adds drop_count, a saturating count of events merged into an already-pending request.
module interrupt_arbiter #(
   parameter logic [26:0] FRAME_ISR_ADDR = 27'd16,
   parameter logic [26:0] JUMP_ISR_ADDR = 27'd64,
   parameter logic [26:0] AUX_ISR_ADDR = 27'd128,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic sysclk,
   input logic reset,
   input logic frame_rt_clk,
   input logic jump_key,
   input logic aux_evt,
   input logic irq_enable,
   input logic irq_ack,
   output logic irq_valid,
   output logic [31:0] interrupt_instruction,
`ifdef IRQ_DROP_COUNT_EN
   output logic [7:0] drop_count,
`endif
   output logic [1:0] irq_src
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
   state_t state, state_d;
   logic [1:0] f_s, j_s, sel, sel_d;
   logic f_d, j_acc, j_hit, frame_rise, jump_rise;
   logic [CW-1:0] j_cnt;
   logic [2:0] pend, set_ev, clr;
   logic [26:0] addr;
   assign frame_rise = f_s[1] & ~f_d;
   assign j_hit = (j_s[1] != j_acc) && (j_cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign jump_rise = j_hit & j_s[1];
   assign set_ev = {aux_evt, jump_rise, frame_rise};
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         f_s <= '0;
         j_s <= '0;
         f_d <= 1'b0;
         j_acc <= 1'b0;
         j_cnt <= '0;
         pend <= '0;
         state <= IDLE;
         sel <= 2'd0;
      end else begin
         f_s <= {f_s[0], frame_rt_clk};
         j_s <= {j_s[0], jump_key};
         f_d <= f_s[1];
         j_cnt <= (j_s[1] == j_acc || j_hit) ? '0 : j_cnt + 1'b1;
         if (j_hit) j_acc <= j_s[1];
         // set wins over an acknowledge clearing the same source
         pend <= (pend & ~clr) | set_ev;
         state <= state_d;
         sel <= sel_d;
      end
   end
   always_comb begin
      state_d = state;
      sel_d = sel;
      clr = 3'b000;
      case (state)
         IDLE: if (irq_enable && pend != 3'b000) begin
            sel_d = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
            state_d = PRESENT;
         end
         PRESENT: if (irq_ack) begin
            clr[sel] = 1'b1;
            state_d = GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   assign addr = sel == 2'd0 ? FRAME_ISR_ADDR : sel == 2'd1 ? JUMP_ISR_ADDR : AUX_ISR_ADDR;
   assign irq_valid = state == PRESENT;
   assign irq_src = irq_valid ? sel : 2'd3;
   assign interrupt_instruction = irq_valid ? {5'b00011, addr} : 32'd0;
`ifdef IRQ_DROP_COUNT_EN
   logic [2:0] merged;
   logic [8:0] drop_sum;
   assign merged = pend & set_ev & ~clr;
   assign drop_sum = {1'b0, drop_count} + 9'(merged[0]) + 9'(merged[1]) + 9'(merged[2]);
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) drop_count <= 8'd0;
      else drop_count <= drop_sum > 9'd255 ? 8'hff : drop_sum[7:0];
   end
`endif
endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_interrupt_arbiter;
   logic sysclk = 0, reset = 1, frame_rt_clk = 0, jump_key = 0, aux_evt = 0, irq_enable = 0, irq_ack = 0;
   logic irq_valid;
   logic [31:0] interrupt_instruction;
   logic [1:0] irq_src;
`ifdef IRQ_DROP_COUNT_EN
   logic [7:0] drop_count;
`endif
   int checks = 0, errors = 0;
   bit [2:0] m_pend, fh, jh;
   bit m_acc, prev_v;
   int m_run, m_phase, m_drop, pres_cnt, p0, lat;
   bit [1:0] m_src;

   interrupt_arbiter dut (
      .sysclk(sysclk), .reset(reset), .frame_rt_clk(frame_rt_clk), .jump_key(jump_key),
      .aux_evt(aux_evt), .irq_enable(irq_enable), .irq_ack(irq_ack), .irq_valid(irq_valid),
      .interrupt_instruction(interrupt_instruction),
`ifdef IRQ_DROP_COUNT_EN
      .drop_count(drop_count),
`endif
      .irq_src(irq_src)
   );

   always #5 sysclk = ~sysclk;

   function automatic [31:0] isr(input bit [1:0] s);
      return s == 0 ? 32'h18000010 : s == 1 ? 32'h18000040 : 32'h18000080;
   endfunction

   task automatic check(input string tag, input [31:0] got, input [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; fh = 0; jh = 0; m_acc = 0; m_run = 0; m_phase = 0; m_src = 0; m_drop = 0; prev_v = 0;
   endtask

   // phase: 0 waiting, 1 presenting, 2 mandatory idle cycle
   task automatic model_step();
      bit [2:0] set, clr;
      set = 0; clr = 0;
      set[0] = fh[1] & ~fh[2];
      if (jh[1] != m_acc) begin
         m_run++;
         if (m_run == 16) begin m_acc = jh[1]; m_run = 0; set[1] = m_acc; end
      end else m_run = 0;
      set[2] = aux_evt;
      fh = {fh[1:0], frame_rt_clk};
      jh = {jh[1:0], jump_key};
      if (m_phase == 1) begin
         if (irq_ack) begin clr[m_src] = 1; m_phase = 2; end
      end else if (m_phase == 2) m_phase = 0;
      else if (irq_enable && m_pend != 0) begin
         m_src = m_pend[0] ? 0 : m_pend[1] ? 1 : 2;
         m_phase = 1;
      end
      for (int i = 0; i < 3; i++) if (set[i] && m_pend[i] && !clr[i] && m_drop < 255) m_drop++;
      m_pend = (m_pend & ~clr) | set;
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
      model_step();
      check("valid", irq_valid, m_phase == 1);
      check("src", irq_src, m_phase == 1 ? m_src : 2'd3);
      check("instr", interrupt_instruction, m_phase == 1 ? isr(m_src) : 32'd0);
      if (irq_valid && !prev_v) pres_cnt++;
      prev_v = irq_valid;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic serve(input bit [1:0] s, output int l);
      l = 0;
      while (!irq_valid && l < 100) begin tick(); l++; end
      check("serve_seen", irq_valid, 1);
      check("serve_src", irq_src, s);
      check("serve_instr", interrupt_instruction, isr(s));
      run(2);
      irq_ack = 1;
      tick();
      irq_ack = 0;
      check("ack_drop", irq_valid, 0);
      tick();
      check("gap", irq_valid, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge sysclk);
      #1;
      check("rst_valid", irq_valid, 0);
      check("rst_src", irq_src, 3);
      check("rst_instr", interrupt_instruction, 0);
      reset = 0;
      irq_enable = 1;
      frame_rt_clk = 1;
      serve(0, lat);
      check("frame_latency", lat, 4);
      frame_rt_clk = 0;
      run(5);
      p0 = pres_cnt;
      jump_key = 1;
      run(20);
      jump_key = 0;
      serve(1, lat);
      run(40);
      check("jump_once", pres_cnt - p0, 1);
      p0 = pres_cnt;
      jump_key = 1;
      run(10);
      jump_key = 0;
      run(40);
      check("glitch", pres_cnt - p0, 0);
      irq_enable = 0;
      frame_rt_clk = 1; run(3); frame_rt_clk = 0;
      jump_key = 1; run(20); jump_key = 0;
      aux_evt = 1; tick(); aux_evt = 0;
      run(30);
      irq_enable = 1;
      serve(0, lat);
      serve(1, lat);
      serve(2, lat);
      irq_enable = 0;
      run(5);
`ifdef IRQ_DROP_COUNT_EN
      p0 = drop_count;
`endif
      repeat (3) begin aux_evt = 1; tick(); aux_evt = 0; run(2); end
      run(5);
      check("aux_blocked", irq_valid, 0);
      p0 = pres_cnt;
      irq_enable = 1;
      serve(2, lat);
      run(10);
      check("aux_once", pres_cnt - p0, 1);
`ifdef IRQ_DROP_COUNT_EN
      check("drop_count", drop_count, m_drop);
`endif
      aux_evt = 1; tick(); aux_evt = 0;
      lat = 0;
      while (!irq_valid && lat < 50) begin tick(); lat++; end
      check("pre_reset_valid", irq_valid, 1);
      #2 reset = 1;
      #1;
      check("async_valid", irq_valid, 0);
      check("async_instr", interrupt_instruction, 0);
      check("async_src", irq_src, 3);
      @(posedge sysclk);
      #1;
      reset = 0;
      model_reset();
      p0 = pres_cnt;
      run(20);
      check("no_represent", pres_cnt - p0, 0);
      aux_evt = 1; tick(); aux_evt = 0;
      lat = 0;
      while (!irq_valid && lat < 50) begin tick(); lat++; end
      irq_ack = 1; aux_evt = 1;
      tick();
      irq_ack = 0; aux_evt = 0;
      check("ack_set_drop", irq_valid, 0);
      serve(2, lat);
      check("aux_repeat_lat", lat, 2);
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(7) == 0) frame_rt_clk = ~frame_rt_clk;
         if ($urandom_range(19) == 0) jump_key = ~jump_key;
         aux_evt = $urandom_range(9) == 0;
         irq_enable = $urandom_range(4) != 0;
         irq_ack = $urandom_range(2) == 0;
         tick();
      end
`ifdef IRQ_DROP_COUNT_EN
      check("drop_random", drop_count, m_drop);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
